// File: rtl/piece_pkg.sv
// Shared piece definitions for the 7-bag piece queue.
// Latency: none, types and pure functions only.
// Backpressure: not applicable.
package piece_pkg;

  typedef logic [2:0] piece_t;

  localparam piece_t PIECE_NONE = 3'd0;
  localparam int     NUM_PIECES = 7;

  // Lowest-numbered ID whose used bit is clear; PIECE_NONE if the bag is exhausted.
  function automatic piece_t lowest_free(input logic [NUM_PIECES-1:0] bag);
    piece_t id;
    id = PIECE_NONE;
    for (int i = NUM_PIECES - 1; i >= 0; i--) begin
      if (!bag[i]) id = piece_t'(i + 1);
    end
    return id;
  endfunction

endpackage

// File: rtl/bag_tracker.sv
// Tracks the 7-bag used-mask and the reject counter, and selects the next candidate piece.
// Latency: candidate is combinational from the current sample; bag/counter update on the next edge.
// Backpressure: when room is low nothing is consumed and the reject counter holds.
import piece_pkg::*;

module bag_tracker #(
  parameter int REJECT_LIMIT = 12
) (
  input  logic   clk,
  input  logic   reset,
  input  piece_t rnd,
  input  logic   room,
  output logic   cand_valid,
  output piece_t cand_id
);

  localparam int RW = $clog2(REJECT_LIMIT + 1);
  localparam logic [RW-1:0] LIMIT = RW'(REJECT_LIMIT);

  logic [NUM_PIECES-1:0] bag;
  logic [NUM_PIECES-1:0] bag_set;
  logic [NUM_PIECES:0]   used;
  logic [RW-1:0]         rej;
  logic                  forced;
  logic                  push;

  // Candidate selection: forced lowest-free pick once the reject budget is spent, else the raw sample.
  always_comb begin
    cand_valid = 1'b0;
    cand_id    = PIECE_NONE;
    // Bit 0 stands for ID 0, which is never a legal piece.
    used       = {bag, 1'b1};
    forced     = (rej == LIMIT);
    if (forced) begin
      cand_id    = lowest_free(bag);
      cand_valid = (cand_id != PIECE_NONE);
    end else if (!used[rnd]) begin
      cand_id    = rnd;
      cand_valid = 1'b1;
    end
    push = room && cand_valid;
    for (int i = 0; i < NUM_PIECES; i++) begin
      bag_set[i] = bag[i] | (cand_id == piece_t'(i + 1));
    end
  end

  // Bag and reject counter: a push marks the piece and restarts the counter; a completed bag restarts.
  always_ff @(posedge clk) begin
    if (reset) begin
      bag <= '0;
      rej <= '0;
    end else if (push) begin
      bag <= (bag_set == '1) ? '0 : bag_set;
      rej <= '0;
    end else if (room && rej != LIMIT) begin
      rej <= rej + 1'b1;
    end
  end

endmodule

// File: rtl/piece_queue.sv
// Circular piece queue fed by a 7-bag randomizer, exposing head and preview pieces.
// Latency: accepted sample shows in Count one cycle later; Next/Preview follow registered state only.
// Backpressure: when full and not popping, samples are ignored; pop and push at full is allowed.
import piece_pkg::*;

module piece_queue #(
  parameter int DEPTH        = 4,
  parameter int REJECT_LIMIT = 12
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic [2:0] Rnd,
  input  logic       Pop,
  output logic [2:0] Next,
  output logic [2:0] Preview,
  output logic [3:0] Count,
  output logic       Ready
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);
  localparam logic [3:0]    FULL = 4'(DEPTH);

  piece_t        mem [DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [PW-1:0] head_n1;
  logic [3:0]    count;
  logic [3:0]    count_nxt;
  logic          ready;
  logic          pop_ok;
  logic          room;
  logic          push;
  logic          cand_valid;
  piece_t        cand_id;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST) ? '0 : p + 1'b1;
  endfunction

  bag_tracker #(
    .REJECT_LIMIT(REJECT_LIMIT)
  ) u_bag (
    .clk       (Clk),
    .reset     (Reset),
    .rnd       (Rnd),
    .room      (room),
    .cand_valid(cand_valid),
    .cand_id   (cand_id)
  );

  // Pop/push qualification and next occupancy.
  always_comb begin
    pop_ok    = Pop && (count != 4'd0);
    room      = (count < FULL) || pop_ok;
    push      = room && cand_valid;
    count_nxt = count;
    case ({push, pop_ok})
      2'b10:   count_nxt = count + 4'd1;
      2'b01:   count_nxt = count - 4'd1;
      default: count_nxt = count;
    endcase
  end

  // Pointers, occupancy and the sticky ready flag.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      ready <= 1'b0;
    end else begin
      if (pop_ok) head <= ptr_inc(head);
      if (push)   tail <= ptr_inc(tail);
      count <= count_nxt;
      ready <= ready | (count_nxt == FULL);
    end
  end

  // Storage write at the tail; contents are qualified by count so they need no reset.
  always_ff @(posedge Clk) begin
    if (!Reset && push) mem[tail] <= cand_id;
  end

  // Head and preview views, derived only from registered state.
  always_comb begin
    head_n1 = ptr_inc(head);
    Next    = (count != 4'd0) ? mem[head]    : PIECE_NONE;
    Preview = (count >= 4'd2) ? mem[head_n1] : PIECE_NONE;
    Count   = count;
    Ready   = ready;
  end

endmodule

// File: tb/tb_piece_queue.sv
module tb_piece_queue;

  logic       Clk   = 1'b0;
  logic       Reset = 1'b1;
  logic [2:0] Rnd   = 3'd0;
  logic       Pop   = 1'b0;
  logic [2:0] Next;
  logic [2:0] Preview;
  logic [3:0] Count;
  logic       Ready;

  int checks = 0;
  int errors = 0;

  piece_queue #(
    .DEPTH(4),
    .REJECT_LIMIT(12)
  ) dut (
    .Clk    (Clk),
    .Reset  (Reset),
    .Rnd    (Rnd),
    .Pop    (Pop),
    .Next   (Next),
    .Preview(Preview),
    .Count  (Count),
    .Ready  (Ready)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic       rst;
    logic [2:0] rnd;
    logic       pop;
    logic [2:0] nxt;
    logic [2:0] prv;
    logic [3:0] cnt;
    logic       rdy;
  } vec_t;

  typedef struct {
    logic [2:0] nxt;
    logic [2:0] prv;
    logic [3:0] cnt;
    logic       rdy;
    int         idx;
  } exp_t;

  exp_t sb[$];

  // Drive one cycle of inputs, let the edge happen, then settle away from it.
  task automatic cycle(input logic r, input logic [2:0] rn, input logic p);
    Reset = r;
    Rnd   = rn;
    Pop   = p;
    @(posedge Clk);
    #1;
  endtask

  task automatic check_outs(input string name, input logic [2:0] en, input logic [2:0] ep,
                            input logic [3:0] ec, input logic er);
    checks++;
    if (Next !== en || Preview !== ep || Count !== ec || Ready !== er) begin
      errors++;
      $display("FAIL %s: got next=%0d preview=%0d count=%0d ready=%0d, want next=%0d preview=%0d count=%0d ready=%0d",
               name, Next, Preview, Count, Ready, en, ep, ec, er);
    end
  endtask

  localparam int NV = 18;
  vec_t v[NV];

  logic [15:0] lfsr;
  logic [7:0]  mask;
  logic [2:0]  id;
  logic        can;
  int          pops;
  int          n;
  exp_t        e;

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {1'b0, s[15:1]} ^ (s[0] ? 16'hB400 : 16'h0000);
  endfunction

  initial begin
    //        rst   rnd   pop   next  prev  cnt   rdy
    v[0]  = '{1'b1, 3'd0, 1'b0, 3'd0, 3'd0, 4'd0, 1'b0};  // reset state
    v[1]  = '{1'b0, 3'd3, 1'b0, 3'd3, 3'd0, 4'd1, 1'b0};  // first accept
    v[2]  = '{1'b0, 3'd3, 1'b0, 3'd3, 3'd0, 4'd1, 1'b0};  // duplicate rejected
    v[3]  = '{1'b0, 3'd0, 1'b0, 3'd3, 3'd0, 4'd1, 1'b0};  // zero rejected
    v[4]  = '{1'b0, 3'd5, 1'b0, 3'd3, 3'd5, 4'd2, 1'b0};
    v[5]  = '{1'b0, 3'd1, 1'b0, 3'd3, 3'd5, 4'd3, 1'b0};
    v[6]  = '{1'b0, 3'd5, 1'b0, 3'd3, 3'd5, 4'd3, 1'b0};  // duplicate rejected
    v[7]  = '{1'b0, 3'd7, 1'b0, 3'd3, 3'd5, 4'd4, 1'b1};  // full -> ready
    v[8]  = '{1'b0, 3'd2, 1'b0, 3'd3, 3'd5, 4'd4, 1'b1};  // full, sample ignored
    v[9]  = '{1'b0, 3'd2, 1'b1, 3'd5, 3'd1, 4'd4, 1'b1};  // pop+push at full
    v[10] = '{1'b0, 3'd0, 1'b1, 3'd1, 3'd7, 4'd3, 1'b1};  // pop only
    v[11] = '{1'b0, 3'd4, 1'b0, 3'd1, 3'd7, 4'd4, 1'b1};  // refill to full
    v[12] = '{1'b1, 3'd6, 1'b1, 3'd0, 3'd0, 4'd0, 1'b0};  // reset beats pop/push
    v[13] = '{1'b0, 3'd0, 1'b1, 3'd0, 3'd0, 4'd0, 1'b0};  // pop on empty
    v[14] = '{1'b0, 3'd0, 1'b1, 3'd0, 3'd0, 4'd0, 1'b0};
    v[15] = '{1'b0, 3'd6, 1'b1, 3'd6, 3'd0, 4'd1, 1'b0};  // empty pop ignored, push lands
    v[16] = '{1'b0, 3'd6, 1'b1, 3'd0, 3'd0, 4'd0, 1'b0};  // pop, duplicate not pushed
    v[17] = '{1'b0, 3'd3, 1'b0, 3'd3, 3'd0, 4'd1, 1'b0};  // 3 free again after reset

    for (int i = 0; i < NV; i++) begin
      e.nxt = v[i].nxt;
      e.prv = v[i].prv;
      e.cnt = v[i].cnt;
      e.rdy = v[i].rdy;
      e.idx = i;
      sb.push_back(e);
      cycle(v[i].rst, v[i].rnd, v[i].pop);
      e = sb.pop_front();
      check_outs($sformatf("vec%0d", e.idx), e.nxt, e.prv, e.cnt, e.rdy);
    end

    // Reset mid-fill with a partly used bag.
    cycle(1'b1, 3'd0, 1'b0);
    cycle(1'b0, 3'd1, 1'b0);
    cycle(1'b0, 3'd2, 1'b0);
    cycle(1'b0, 3'd3, 1'b0);
    check_outs("midreset_pre", 3'd1, 3'd2, 4'd3, 1'b0);
    cycle(1'b1, 3'd4, 1'b1);
    check_outs("midreset_clear", 3'd0, 3'd0, 4'd0, 1'b0);
    cycle(1'b0, 3'd1, 1'b0);
    check_outs("midreset_refill1", 3'd1, 3'd0, 4'd1, 1'b0);
    cycle(1'b0, 3'd3, 1'b0);
    check_outs("midreset_refill2", 3'd1, 3'd3, 4'd2, 1'b0);

    // Forced pick: bag holds 1..6, Rnd stuck on a used ID.
    cycle(1'b1, 3'd0, 1'b0);
    cycle(1'b0, 3'd1, 1'b0);
    cycle(1'b0, 3'd2, 1'b0);
    cycle(1'b0, 3'd3, 1'b0);
    cycle(1'b0, 3'd4, 1'b0);
    check_outs("forced_fill", 3'd1, 3'd2, 4'd4, 1'b1);
    cycle(1'b0, 3'd5, 1'b1);
    cycle(1'b0, 3'd6, 1'b1);
    check_outs("forced_bag6", 3'd3, 3'd4, 4'd4, 1'b1);
    for (int k = 1; k <= 12; k++) begin
      cycle(1'b0, 3'd2, (k <= 4));
      checks++;
      if (Count !== ((k <= 4) ? 4'(4 - k) : 4'd0)) begin
        errors++;
        $display("FAIL forced_reject%0d: got count=%0d, want count=%0d", k, Count,
                 (k <= 4) ? (4 - k) : 0);
      end
    end
    cycle(1'b0, 3'd2, 1'b0);
    check_outs("forced_pick7", 3'd7, 3'd0, 4'd1, 1'b1);
    cycle(1'b0, 3'd2, 1'b0);
    check_outs("forced_bag_cleared", 3'd7, 3'd2, 4'd2, 1'b1);

    // Bag completeness under an LFSR source with continuous popping.
    lfsr = 16'hACE1;
    cycle(1'b1, 3'd0, 1'b0);
    n = 0;
    while (!Ready && n < 500) begin
      cycle(1'b0, lfsr[2:0], 1'b0);
      lfsr = lfsr_step(lfsr);
      n++;
    end
    checks++;
    if (!Ready) begin
      errors++;
      $display("FAIL lfsr_ready_timeout: got ready=%0d after %0d cycles, want 1", Ready, n);
    end
    pops = 0;
    n    = 0;
    mask = 8'h00;
    while (pops < 70 && n < 3000) begin
      id  = Next;
      can = (Count != 4'd0);
      cycle(1'b0, lfsr[2:0], 1'b1);
      lfsr = lfsr_step(lfsr);
      n++;
      if (can) begin
        mask = mask | (8'd1 << id);
        pops++;
        if (pops % 7 == 0) begin
          checks++;
          if (mask !== 8'hFE) begin
            errors++;
            $display("FAIL bag_group%0d: got id mask=%02h, want fe", pops / 7, mask);
          end
          mask = 8'h00;
        end
      end
    end
    checks++;
    if (pops < 70) begin
      errors++;
      $display("FAIL lfsr_pop_timeout: got %0d pops, want 70", pops);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
